// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: req/ack fetch FSM feeding a DEPTH-entry {pc, instr} FIFO.
// Define INSTR_PREFETCH_BYPASS_EN to forward a returning word straight to the head when empty.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    input  logic                       deq_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    output logic                       valid_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                pc_add4_o,
    output logic [31:0]                instr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam int unsigned CntW     = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [31:0] Nop      = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StKill
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     pending_pc_q, pending_pc_d;

    logic [31:0]     mem_pc_q    [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            fifo_empty;
    logic            bypass;
    logic            enq;
    logic            pop;
    logic [CntW-1:0] count_post;

    assign fifo_empty = (count_q == '0);

`ifdef INSTR_PREFETCH_BYPASS_EN
    assign bypass = fifo_empty && (state_q == StReq) && imem_ack_i && !redirect_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that is consumed in the same cycle never touches storage.
    assign pop = deq_i && !fifo_empty && !redirect_i;
    assign enq = (state_q == StReq) && imem_ack_i && !redirect_i && !(bypass && deq_i);

    assign count_post = count_q + CntW'(enq) - CntW'(pop);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        unique case (state_q)
            StIdle: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    state_d    = StReq;
                end else if (count_post < DepthCnt) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        fetch_pc_d = redirect_pc_i;
                    end else begin
                        // Keep the address stable until the in-flight access completes.
                        pending_pc_d = redirect_pc_i;
                        state_d      = StKill;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_post < DepthCnt) ? StReq : StIdle;
                end
            end
            StKill: begin
                if (imem_ack_i) begin
                    fetch_pc_d = redirect_i ? redirect_pc_i : pending_pc_q;
                    state_d    = StReq;
                end else if (redirect_i) begin
                    pending_pc_d = redirect_pc_i;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_post;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is masked by fifo_empty until written.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_data_i;
        end
    end

    assign imem_req_o  = (state_q != StIdle);
    assign imem_addr_o = fetch_pc_q;
    assign count_o     = count_q;

    always_comb begin
        valid_o = !fifo_empty;
        pc_o    = mem_pc_q[rd_ptr_q];
        instr_o = mem_instr_q[rd_ptr_q];
        if (fifo_empty) begin
            pc_o    = '0;
            instr_o = Nop;
        end
`ifdef INSTR_PREFETCH_BYPASS_EN
        if (bypass) begin
            valid_o = 1'b1;
            pc_o    = fetch_pc_q;
            instr_o = imem_data_i;
        end
`endif
    end

    assign pc_add4_o = pc_o + 32'd4;

endmodule
